// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states,
// iterative-unit modes and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_MULU  = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing
// one accumulator/shift register pair and one iteration counter.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_mode_e         mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt,
  output logic             divisor_zero
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] shr_q;
  logic [WIDTH-1:0] opb_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  // acc holds the running high product / partial remainder; shr holds the
  // multiplier bits still to consume, or the dividend bits shifting out
  // while quotient bits shift in. A zero divisor naturally yields an
  // all-ones quotient and the dividend as remainder.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, shr_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    hi_nxt    = acc_q;
    lo_nxt    = shr_q;
    if (mode == MD_MUL) begin
      {hi_nxt, lo_nxt} = {mul_sum, shr_q[WIDTH-1:1]};
    end else begin
      hi_nxt = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
      lo_nxt = {shr_q[WIDTH-2:0], div_ge};
    end
  end

  assign last         = (cnt_q == CNT_W'(WIDTH - 1));
  assign divisor_zero = (opb_q == '0);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      shr_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      shr_q <= a;
      opb_q <= b;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= hi_nxt;
      shr_q <= lo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/pass, iterative MULU/DIVU,
// results and flags registered on entry to DONE and held until accepted.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_f,
  output logic             overflow_f,
  output logic             negative_f,
  output logic             zero_f
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              accept;
  logic              md_start, md_step, load_alu, load_md;
  md_mode_e          md_mode;
  logic              md_last, md_div_zero;
  logic [WIDTH-1:0]  md_lo, md_hi;

  logic              is_sub;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_v;

  logic [WIDTH-1:0]  fin_res, fin_hi;
  logic              fin_c, fin_v;

  logic [WIDTH-1:0]  result_q, result_hi_q;
  logic [FLAG_W-1:0] flags_q;

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (md_start),
    .mode         (md_mode),
    .step         (md_step),
    .a            (a),
    .b            (b),
    .last         (md_last),
    .lo_nxt       (md_lo),
    .hi_nxt       (md_hi),
    .divisor_zero (md_div_zero)
  );

  always_comb begin
    state_d  = state_q;
    accept   = in_valid && in_ready_q;
    md_start = 1'b0;
    md_step  = 1'b0;
    md_mode  = MD_MUL;
    load_alu = 1'b0;
    load_md  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_sel == OP_MULU) begin
            state_d  = ST_MUL;
            md_start = 1'b1;
          end else if (op_sel == OP_DIVU) begin
            state_d  = ST_DIV;
            md_start = 1'b1;
          end else begin
            state_d  = ST_DONE;
            load_alu = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        md_step = 1'b1;
        md_mode = (state_q == ST_DIV) ? MD_DIV : MD_MUL;
        if (md_last) begin
          state_d = ST_DONE;
          load_md = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  always_comb begin
    is_sub  = (op_sel == OP_SUB);
    b_eff   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    fin_res = alu_res;
    fin_hi  = '0;
    fin_c   = alu_c;
    fin_v   = alu_v;
    if (load_md) begin
      fin_res = md_lo;
      fin_hi  = md_hi;
      fin_c   = (state_q == ST_MUL) && (md_hi != '0);
      fin_v   = (state_q == ST_DIV) && md_div_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Outputs only move on the edge that enters DONE; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else if (load_alu || load_md) begin
      result_q            <= fin_res;
      result_hi_q         <= fin_hi;
      flags_q[FLAG_C]     <= fin_c;
      flags_q[FLAG_V]     <= fin_v;
      flags_q[FLAG_N]     <= fin_res[WIDTH-1];
      flags_q[FLAG_Z]     <= (fin_res == '0);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign carry_f    = flags_q[FLAG_C];
  assign overflow_f = flags_q[FLAG_V];
  assign negative_f = flags_q[FLAG_N];
  assign zero_f     = flags_q[FLAG_Z];

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): arithmetic reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op_sel;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result, result_hi;
  logic          carry_f, overflow_f, negative_f, zero_f;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flags;  // {c, v, n, z}
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic was_valid = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .carry_f    (carry_f),
    .overflow_f (overflow_f),
    .negative_f (negative_f),
    .zero_f     (zero_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] wide;
    longint      s;
    logic        c, v;
    e.hi = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        wide = {32'b0, x} + {32'b0, y};
        e.res = wide[31:0];
        c = wide[32];
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.res = x - y;
        c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = y;
      3'd6: begin
        wide = {32'b0, x} * {32'b0, y};
        e.res = wide[31:0];
        e.hi  = wide[63:32];
        c = (e.hi != 0);
      end
      default: begin
        if (y == 0) begin
          e.res = '1;
          e.hi  = x;
          v = 1'b1;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
      end
    endcase
    e.flags   = {c, v, e.res[W-1], (e.res == 0)};
    e.lat     = (op >= 3'd6) ? W + 1 : 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      was_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_without_op", {63'b0, out_valid}, 64'd0);
        end else begin
          check("model_result", {32'b0, result}, {32'b0, exp_q[0].res});
          check("model_result_hi", {32'b0, result_hi}, {32'b0, exp_q[0].hi});
          check("model_flags_cvnz", {60'b0, carry_f, overflow_f, negative_f, zero_f},
                {60'b0, exp_q[0].flags});
          check("busy_in_ready_low", {63'b0, in_ready}, 64'd0);
          if (!was_valid)
            check("model_latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        check("busy_in_ready_low", {63'b0, in_ready}, 64'd0);
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(op_sel, a, b);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
      was_valid = out_valid && !out_ready;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit got = 1'b0;
    @(posedge clk); #1;
    op_sel = op; a = x; b = y; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op_sel = 3'($urandom);
  endtask

  task automatic wait_done(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      lat++;
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r, input logic [W-1:0] h,
                            input logic [3:0] cvnz);
    check({name, "_result"}, {32'b0, result}, {32'b0, r});
    check({name, "_result_hi"}, {32'b0, result_hi}, {32'b0, h});
    check({name, "_cvnz"}, {60'b0, carry_f, overflow_f, negative_f, zero_f}, {60'b0, cvnz});
  endtask

  initial begin
    int lat;
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; op_sel = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_in_ready", {63'b0, in_ready}, 64'd0);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    expect_out("reset", 32'h0, 32'h0, 4'b0000);
    @(negedge clk) rst_n = 1'b1;

    issue(3'd0, 32'h7FFF_FFFF, 32'h1);
    wait_done(lat);
    check("add_latency", 64'(lat), 64'd1);
    expect_out("add_ovf", 32'h8000_0000, 32'h0, 4'b0110);

    issue(3'd1, 32'd5, 32'd5);
    wait_done(lat);
    expect_out("sub_eq", 32'h0, 32'h0, 4'b1001);

    issue(3'd1, 32'd0, 32'd1);
    wait_done(lat);
    expect_out("sub_borrow", 32'hFFFF_FFFF, 32'h0, 4'b0010);

    issue(3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F);
    wait_done(lat);
    expect_out("and", 32'h0F00_0F00, 32'h0, 4'b0000);

    issue(3'd3, 32'hFF00_FF00, 32'h0F0F_0F0F);
    wait_done(lat);
    expect_out("or", 32'hFF0F_FF0F, 32'h0, 4'b0010);

    issue(3'd5, 32'hDEAD_BEEF, 32'h0000_0000);
    wait_done(lat);
    expect_out("passb_zero", 32'h0, 32'h0, 4'b0001);

    issue(3'd6, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat);
    check("mul_latency", 64'(lat), 64'd33);
    expect_out("mulu", 32'hFFFF_FFFE, 32'h1, 4'b1010);

    issue(3'd7, 32'd100, 32'd7);
    wait_done(lat);
    expect_out("divu", 32'd14, 32'd2, 4'b0000);

    issue(3'd7, 32'h1234, 32'd0);
    wait_done(lat);
    check("div0_latency", 64'(lat), 64'd33);
    expect_out("divu_zero", 32'hFFFF_FFFF, 32'h1234, 4'b0110);

    // Backpressure: hold the XOR result while the producer keeps requesting.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_done(lat);
    expect_out("xor", 32'hFF00_EDCB, 32'h0, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op_sel = 3'd0; a = $urandom; b = $urandom;
      @(negedge clk);
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      check("bp_result_held", {32'b0, result}, 64'hFF00_EDCB);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op_sel = 3'd0; a = 32'd10; b = 32'd20;
    @(negedge clk);
    check("release_in_ready_still_low", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    check("release_in_ready_next", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("after_bp_valid", {63'b0, out_valid}, 64'd1);
    expect_out("after_bp_add", 32'd30, 32'h0, 4'b0000);

    // Reset in the middle of a multiply.
    issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2;
    check("mul_busy_result_held", {32'b0, result}, 64'd30);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", {63'b0, in_ready}, 64'd0);
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    expect_out("midreset", 32'h0, 32'h0, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("post_reset_out_valid", {63'b0, out_valid}, 64'd0);
    issue(3'd0, 32'd2, 32'd3);
    wait_done(lat);
    check("post_reset_add_latency", 64'(lat), 64'd1);
    expect_out("post_reset_add", 32'd5, 32'h0, 4'b0000);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
